rpu_slot_manager: RTL

- Core-side end of the load-balancer control channel; one instance per RPU.
- Receives slot configuration and flush commands from the load-balancer controller, and tracks which of the core's packet slots are occupied.
- When the core releases a slot, it returns a slot-free descriptor to the controller.
- Sits between the RPU's control-channel ports and the core's packet-arrival and release strobes.

---
 rtl/rpu_ctrl_pkg.sv | 31 +++
 rtl/rpu_slot_manager_if.sv | 38 +++
 rtl/rpu_ctrl_out_reg.sv | 26 ++
 rtl/rpu_slot_manager.sv | 95 +++++++++
 4 files changed

// File: rtl/rpu_ctrl_pkg.sv
// rpu_ctrl_pkg: control-channel word layout, type codes and message builders shared by the RPU core and the load-balancer controller
package rpu_ctrl_pkg;
  localparam int CTRL_WIDTH = 36;
  localparam int TYPE_LSB = 32;
  localparam int TYPE_W = 4;
  localparam int TAG_LSB = 0;
  localparam int TAG_W = 8;
  localparam int LEN_LSB = 8;
  localparam int LEN_W = 16;
  localparam int PORT_LSB = 24;
  localparam int PORT_W = 3;
  typedef enum logic [TYPE_W-1:0] {CMD_SET_SLOTS = 4'd1, CMD_FLUSH = 4'd2} cmd_type_e;
  typedef enum logic [TYPE_W-1:0] {MSG_SLOT_FREE = 4'd0, MSG_SLOT_INIT = 4'd1} msg_type_e;
  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_e;
  function automatic logic [CTRL_WIDTH-1:0] slot_init_msg(input logic [TAG_W-1:0] tag);
    logic [CTRL_WIDTH-1:0] m;
    m = '0;
    m[TYPE_LSB +: TYPE_W] = MSG_SLOT_INIT;
    m[TAG_LSB +: TAG_W] = tag;
    return m;
  endfunction
  function automatic logic [CTRL_WIDTH-1:0] slot_free_msg(input logic [TAG_W-1:0] tag, input logic [LEN_W-1:0] len, input logic [PORT_W-1:0] port);
    logic [CTRL_WIDTH-1:0] m;
    m = '0;
    m[TYPE_LSB +: TYPE_W] = MSG_SLOT_FREE;
    m[TAG_LSB +: TAG_W] = tag;
    m[LEN_LSB +: LEN_W] = len;
    m[PORT_LSB +: PORT_W] = port;
    return m;
  endfunction
endpackage

// File: rtl/rpu_slot_manager_if.sv
// rpu_slot_manager_if: control-channel streams, packet arrival/release strobes and slot status; slave = slot manager, master = surrounding core/controller
interface rpu_slot_manager_if
  import rpu_ctrl_pkg::*;
#(
  parameter int SLOT_COUNT = 32,
  parameter int TAG_WIDTH = 6,
  parameter int LEN_WIDTH = 16,
  parameter int PORT_WIDTH = 3
);
  logic [CTRL_WIDTH-1:0] ctrl_s_axis_tdata;
  logic ctrl_s_axis_tvalid;
  logic ctrl_s_axis_tready;
  logic [CTRL_WIDTH-1:0] ctrl_m_axis_tdata;
  logic ctrl_m_axis_tvalid;
  logic ctrl_m_axis_tready;
  logic pkt_in_valid;
  logic [TAG_WIDTH-1:0] pkt_in_tag;
  logic rel_valid;
  logic rel_ready;
  logic [TAG_WIDTH-1:0] rel_tag;
  logic [LEN_WIDTH-1:0] rel_len;
  logic [PORT_WIDTH-1:0] rel_port;
  logic [SLOT_COUNT-1:0] slot_busy;
  logic [TAG_WIDTH-1:0] slot_limit;
  logic ins_err;
  modport slave (
    input ctrl_s_axis_tdata, ctrl_s_axis_tvalid, ctrl_m_axis_tready,
    input pkt_in_valid, pkt_in_tag, rel_valid, rel_tag, rel_len, rel_port,
    output ctrl_s_axis_tready, ctrl_m_axis_tdata, ctrl_m_axis_tvalid,
    output rel_ready, slot_busy, slot_limit, ins_err
  );
  modport master (
    output ctrl_s_axis_tdata, ctrl_s_axis_tvalid, ctrl_m_axis_tready,
    output pkt_in_valid, pkt_in_tag, rel_valid, rel_tag, rel_len, rel_port,
    input ctrl_s_axis_tready, ctrl_m_axis_tdata, ctrl_m_axis_tvalid,
    input rel_ready, slot_busy, slot_limit, ins_err
  );
endinterface

// File: rtl/rpu_ctrl_out_reg.sv
// rpu_ctrl_out_reg: single-entry AXI-stream holding register; load/load_data/can_load on the fill side, m_tdata/m_tvalid/m_tready on the stream side
module rpu_ctrl_out_reg #(
  parameter int WIDTH = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [WIDTH-1:0] load_data,
  output logic can_load,
  output logic [WIDTH-1:0] m_tdata,
  output logic m_tvalid,
  input  logic m_tready
);
  assign can_load = !m_tvalid || m_tready;
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata <= '0;
      m_tvalid <= 1'b0;
    end else if (load) begin
      m_tdata <= load_data;
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/rpu_slot_manager.sv
// rpu_slot_manager: core-side control endpoint; clk/rst plus bus (commands in, SLOT_INIT/SLOT_FREE out, arrival/release strobes, slot_busy/slot_limit/ins_err status)
module rpu_slot_manager
  import rpu_ctrl_pkg::*;
#(
  parameter int SLOT_COUNT = 32,
  parameter int TAG_WIDTH = 6,
  parameter int LEN_WIDTH = 16,
  parameter int PORT_WIDTH = 3
) (
  input logic clk,
  input logic rst,
  rpu_slot_manager_if.slave bus
);
  localparam logic [TAG_WIDTH-1:0] MAX_TAG = TAG_WIDTH'(SLOT_COUNT);
  state_e state, state_n;
  logic [TAG_WIDTH-1:0] init_cnt, init_cnt_n, limit, limit_n, n_raw, n_clamp;
  logic [SLOT_COUNT-1:0] busy, busy_n, rel_mask, arr_mask, base;
  logic err, err_n, cmd_fire, set_go, flush_go, reinit, rel_fire, rel_ok, arr_ok, load, can_load;
  logic [TYPE_W-1:0] cmd_type;
  logic [CTRL_WIDTH-1:0] load_data;
  logic [LEN_WIDTH-1:0] rel_len;
  logic [PORT_WIDTH-1:0] rel_port;
  function automatic logic [SLOT_COUNT-1:0] tag_mask(input logic [TAG_WIDTH-1:0] t);
    return (t == '0 || t > MAX_TAG) ? '0 : SLOT_COUNT'(1) << (t - 1'b1);
  endfunction
  assign rel_len = bus.rel_len;
  assign rel_port = bus.rel_port;
  assign bus.ctrl_s_axis_tready = state != ST_INIT;
  assign cmd_type = bus.ctrl_s_axis_tdata[TYPE_LSB +: TYPE_W];
  assign cmd_fire = bus.ctrl_s_axis_tvalid && bus.ctrl_s_axis_tready;
  assign n_raw = bus.ctrl_s_axis_tdata[TAG_WIDTH-1:0];
  assign n_clamp = n_raw > MAX_TAG ? MAX_TAG : n_raw;
  assign set_go = cmd_fire && cmd_type == CMD_SET_SLOTS && n_raw != '0;
  assign flush_go = cmd_fire && cmd_type == CMD_FLUSH && state == ST_RUN;
  assign reinit = set_go || flush_go;
  // Any accepted command, even one that is dropped, blocks a release that cycle.
  assign bus.rel_ready = state == ST_RUN && can_load && !cmd_fire;
  assign rel_fire = bus.rel_valid && bus.rel_ready;
  assign rel_mask = tag_mask(bus.rel_tag);
  assign rel_ok = bus.rel_tag != '0 && bus.rel_tag <= limit && |(busy & rel_mask);
  // Release clears before arrival sets, so a same-tag pair leaves the slot busy without error.
  assign base = reinit ? '0 : busy & ~(rel_fire && rel_ok ? rel_mask : '0);
  assign arr_mask = tag_mask(bus.pkt_in_tag);
  assign arr_ok = bus.pkt_in_tag != '0 && bus.pkt_in_tag <= limit && !(|(base & arr_mask));
  assign busy_n = base | (bus.pkt_in_valid && arr_ok ? arr_mask : '0);
  assign err_n = (err && !flush_go) || (rel_fire && !rel_ok) || (bus.pkt_in_valid && !arr_ok);
  assign bus.slot_busy = busy;
  assign bus.slot_limit = limit;
  assign bus.ins_err = err;
  always_comb begin
    state_n = state;
    init_cnt_n = init_cnt;
    limit_n = limit;
    load = 1'b0;
    load_data = '0;
    if (reinit) begin
      state_n = ST_INIT;
      init_cnt_n = TAG_WIDTH'(1);
      limit_n = set_go ? n_clamp : limit;
    end else if (state == ST_INIT && can_load) begin
      load = 1'b1;
      load_data = slot_init_msg(8'(init_cnt));
      init_cnt_n = init_cnt + 1'b1;
      state_n = init_cnt == limit ? ST_RUN : ST_INIT;
    end else if (rel_fire && rel_ok) begin
      load = 1'b1;
      load_data = slot_free_msg(8'(bus.rel_tag), 16'(rel_len), 3'(rel_port));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      init_cnt <= '0;
      limit <= '0;
      busy <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      init_cnt <= init_cnt_n;
      limit <= limit_n;
      busy <= busy_n;
      err <= err_n;
    end
  end
  rpu_ctrl_out_reg #(.WIDTH(CTRL_WIDTH)) u_out (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_data(load_data),
    .can_load(can_load),
    .m_tdata(bus.ctrl_m_axis_tdata),
    .m_tvalid(bus.ctrl_m_axis_tvalid),
    .m_tready(bus.ctrl_m_axis_tready)
  );
endmodule
